// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pin bundle between an external master and spi_slave
interface spi_slave_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (
    output sclk,
    output cs_n,
    output mosi,
    input  miso,
    input  miso_oe
  );

  modport slave (
    input  sclk,
    input  cs_n,
    input  mosi,
    output miso,
    output miso_oe
  );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 register slave, optional odd parity via SPI_SLAVE_PARITY_EN
module spi_slave #(
  parameter int ADDRWIDTH = 3,
  parameter int DATAWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  spi_slave_if.slave           spi,
  input  logic [ADDRWIDTH-1:0] loc_addr,
  output logic [DATAWIDTH-1:0] loc_rdata,
  output logic                 wr_pulse,
  output logic                 frame_err
);

`ifdef SPI_SLAVE_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // Data phase length including the trailing parity bit when enabled.
  localparam int DBITS = DATAWIDTH + PBITS;
  localparam int MAXB  = (ADDRWIDTH > DBITS) ? ADDRWIDTH : DBITS;
  localparam int CW    = $clog2(MAXB + 1);
  localparam int NREGS = 2 ** ADDRWIDTH;
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDRWIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DBITS - 1);
`ifdef SPI_SLAVE_PARITY_EN
  localparam logic [CW-1:0] DATA_END  = CW'(DATAWIDTH);
`endif

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, WAIT_CS} state_t;

  state_t state_q, state_d;

  logic [1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_d, cs_d;
  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_fall;

  logic                 rw_q;
  logic [ADDRWIDTH-1:0] addr_q, addr_in;
  logic [DATAWIDTH-1:0] data_q, data_in, commit_data;
  logic [DBITS-1:0]     tx_q;
  logic                 oe_q;
  logic [CW-1:0]        cnt_q;
  logic [DATAWIDTH-1:0] regs [NREGS];
  logic                 wr_pulse_q, frame_err_q;

  logic commit, abort, bad_par, load_tx, shift_tx;

  assign sclk_s    = sclk_sync[1];
  assign cs_s      = cs_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;

  // Shift registers with the bit currently on mosi appended at the LSB.
  assign addr_in = ADDRWIDTH'({addr_q, mosi_s});
  assign data_in = DATAWIDTH'({data_q, mosi_s});

`ifdef SPI_SLAVE_PARITY_EN
  assign commit_data = data_q;
`else
  assign commit_data = data_in;
`endif

  assign loc_rdata   = regs[loc_addr];
  assign spi.miso    = oe_q & tx_q[DBITS-1];
  assign spi.miso_oe = oe_q;
  assign wr_pulse    = wr_pulse_q;
  assign frame_err   = frame_err_q;

  // Two-flop synchronizers for the SPI pins plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[0], spi.sclk};
      cs_sync   <= {cs_sync[0], spi.cs_n};
      mosi_sync <= {mosi_sync[0], spi.mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode and per-cycle datapath strobes; a final sample beats a same-cycle cs_n rise.
  always_comb begin
    state_d  = state_q;
    commit   = 1'b0;
    abort    = 1'b0;
    bad_par  = 1'b0;
    load_tx  = 1'b0;
    shift_tx = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) state_d = CMD;
      end
      CMD: begin
        if (cs_s) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (sclk_rise) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (cs_s) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (sclk_rise && cnt_q == ADDR_LAST) begin
          state_d = DATA;
          load_tx = ~rw_q;
        end
      end
      DATA: begin
        if (sclk_rise && cnt_q == DATA_LAST) begin
          state_d = WAIT_CS;
          if (rw_q) begin
`ifdef SPI_SLAVE_PARITY_EN
            if (^{rw_q, addr_q, data_q, mosi_s}) commit  = 1'b1;
            else                                 bad_par = 1'b1;
`else
            commit = 1'b1;
`endif
          end
        end else if (cs_s) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (sclk_fall && cnt_q != '0 && !rw_q) begin
          // The first falling edge of the data phase keeps the MSB loaded at the address phase.
          shift_tx = 1'b1;
        end
      end
      WAIT_CS: begin
        if (cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit counter, command/address/data shifting, register commit, read shifter and pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rw_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      tx_q        <= '0;
      oe_q        <= 1'b0;
      cnt_q       <= '0;
      wr_pulse_q  <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      wr_pulse_q  <= commit;
      frame_err_q <= abort | bad_par;

      if (state_d != state_q)                         cnt_q <= '0;
      else if (sclk_rise && state_q inside {ADDR, DATA}) cnt_q <= cnt_q + 1'b1;

      if (sclk_rise) begin
        case (state_q)
          CMD:  rw_q   <= mosi_s;
          ADDR: addr_q <= addr_in;
          DATA: begin
`ifdef SPI_SLAVE_PARITY_EN
            if (cnt_q < DATA_END) data_q <= data_in;
`else
            data_q <= data_in;
`endif
          end
          default: ;
        endcase
      end

      if (commit) regs[addr_q] <= commit_data;

      if (load_tx)                oe_q <= 1'b1;
      else if (state_d != DATA)   oe_q <= 1'b0;

`ifdef SPI_SLAVE_PARITY_EN
      if (load_tx)       tx_q <= {regs[addr_in], ~^{rw_q, addr_in, regs[addr_in]}};
`else
      if (load_tx)       tx_q <= regs[addr_in];
`endif
      else if (shift_tx) tx_q <= tx_q << 1;
    end
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter ADDRWIDTH, default 3, sets the register address width and register count (2**ADDRWIDTH).
REQ-002 Parameter DATAWIDTH, default 8, sets the register and data-field width.
REQ-003 Port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 Port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 Port sclk, input, 1 bit, SPI clock from the master, asynchronous to clk.
REQ-006 Port cs_n, input, 1 bit, active-low chip select from the master, asynchronous.
REQ-007 Port mosi, input, 1 bit, serial data from the master, asynchronous.
REQ-008 Port miso, output, 1 bit, serial data to the master.
REQ-009 Port miso_oe, output, 1 bit, MISO drive enable; high only during the read data phase.
REQ-010 Port loc_addr, input, ADDRWIDTH bits, local readback address.
REQ-011 Port loc_rdata, output, DATAWIDTH bits, combinational readback of register[loc_addr].
REQ-012 Port wr_pulse, output, 1 bit, one-clk pulse when an SPI write commits.
REQ-013 Port frame_err, output, 1 bit, one-clk pulse on an aborted or bad frame.

Function
REQ-014 sclk, cs_n and mosi each pass through a 2-flop synchronizer; sclk edges are detected from the synchronized value; clk frequency is at least 8x sclk.
REQ-015 SPI mode 0, MSB first: mosi is sampled on detected sclk rising edges and miso is updated on detected sclk falling edges.
REQ-016 Frame layout: 1 rw bit (1=write, 0=read), then ADDRWIDTH address bits, then DATAWIDTH data bits.
REQ-017 FSM states: IDLE, CMD, ADDR, DATA, WAIT_CS.
REQ-018 IDLE goes to CMD on synchronized cs_n falling.
REQ-019 CMD goes to ADDR after 1 sampled bit.
REQ-020 ADDR goes to DATA after ADDRWIDTH sampled bits; a bit counter tracks position within each phase.
REQ-021 DATA goes to WAIT_CS after DATAWIDTH bits (plus parity, see REQ-032); WAIT_CS goes to IDLE on cs_n high.
REQ-022 Write commit: on the final data sample, register[addr] is loaded with the shifted data and wr_pulse is asserted for 1 clk in the same cycle.
REQ-023 Read: register[addr] is loaded into a shift register when the last address bit is sampled.
REQ-024 Read output: miso_oe rises and miso presents the data MSB before the next sclk rising edge; each following falling edge shifts the next bit.
REQ-025 miso is 0 whenever miso_oe is 0; miso_oe drops when the FSM leaves DATA or cs_n rises.
REQ-026 Abort: cs_n rising in CMD, ADDR or DATA returns the FSM to IDLE with no register write and a 1-clk frame_err pulse.
REQ-027 Extra sclk edges in WAIT_CS are ignored, with no error.
REQ-028 If cs_n rises and a final data sample occur in the same clk, the commit wins and no frame_err is raised.

Reset
REQ-029 reset_n low asynchronously clears all registers to 0, clears the synchronizers to idle values (sclk=0, cs_n=1, mosi=0), and sets the FSM to IDLE.
REQ-030 During reset, miso=0, miso_oe=0, wr_pulse=0 and frame_err=0.
REQ-031 Reset asserted mid-frame discards the frame; after release, the FSM waits for a fresh cs_n falling edge.

Configuration
REQ-032 With macro SPI_SLAVE_PARITY_EN defined, every frame carries one extra odd-parity bit after the data, computed over rw, address and data.
REQ-033 With SPI_SLAVE_PARITY_EN, a write commits only if parity is correct; otherwise frame_err pulses and the register is unchanged.
REQ-034 With SPI_SLAVE_PARITY_EN, on a read the slave drives the parity bit on miso after the data LSB.
REQ-035 Without SPI_SLAVE_PARITY_EN, no parity bit exists and the frame is 1+ADDRWIDTH+DATAWIDTH bits.

Verification
REQ-036 Write frame 1,011,0xA5 with clk=8x sclk -> register[3]=0xA5, one wr_pulse, loc_addr=3 gives loc_rdata=0xA5.
REQ-037 After REQ-036, read frame 0,011 -> miso shifts 10100101 with miso_oe high for exactly 8 sclk periods, then returns low.
REQ-038 Write frame to address 5 with cs_n raised after 4 data bits -> register[5] remains 0, one frame_err pulse, no wr_pulse.
REQ-039 Reset asserted mid-write, then a full write of 0x3C to address 7 -> register[7]=0x3C, all other registers 0.
REQ-040 SPI_SLAVE_PARITY_EN defined, write 0x01 to address 0 with bad parity -> register unchanged, frame_err pulses; same frame with correct parity -> register[0]=0x01.
